// File: rtl/icache_fill_decomp.sv
`default_nettype none
// ============================================================================
// Module   : icache_fill_decomp
// Purpose  : Serves icache line fills by expanding 16-bit dictionary codes,
//            with a one-word code buffer and raw-word escape fetches.
// Revision : 1.0 - initial release
// ============================================================================
module icache_fill_decomp #(
  parameter int unsigned DICT_ENTRIES = 256,
  parameter logic [31:0] DICT_BASE    = 32'h0002_0000,
  parameter logic [31:0] CODE_BASE    = 32'h0001_0000,
  parameter logic [31:0] RAW_BASE     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        up_valid,
  output logic        up_ready,
  input  logic [31:0] up_addr,
  output logic [31:0] up_rdata,
  output logic        dn_valid,
  input  logic        dn_ready,
  output logic [31:0] dn_addr,
  input  logic [31:0] dn_rdata,
  output logic        load_done,
  output logic [31:0] dict_hits,
  output logic [31:0] raw_fetches
);

  localparam int unsigned DICT_BITS = $clog2(DICT_ENTRIES);
  localparam logic [DICT_BITS-1:0] c_LAST_IDX = DICT_BITS'(DICT_ENTRIES - 1);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_IDLE   = 3'd1,
    S_CODE   = 3'd2,
    S_DECODE = 3'd3,
    S_RAW    = 3'd4,
    S_RESP   = 3'd5,
    S_DROP   = 3'd6
  } state_t;

  state_t                r_state, w_state_d;
  logic [DICT_BITS-1:0]  r_load_idx, w_load_idx_d;
  logic [31:2]           r_addr;
  logic [31:0]           r_buf_data;
  logic [31:0]           r_buf_tag;
  logic                  r_buf_valid;
  logic                  r_abort, w_abort_d;
  logic                  r_up_ready, w_up_ready_d;
  logic [31:0]           r_up_rdata, w_up_rdata_d;
  logic                  r_dn_valid, w_dn_valid_d;
  logic [31:0]           r_dn_addr, w_dn_addr_d;
  logic                  r_load_done, w_load_done_d;
  logic [31:0]           r_dict_hits, r_raw_fetches;
  logic [31:0]           r_dict [DICT_ENTRIES];

  logic                  w_hit_inc, w_raw_inc, w_dict_wr, w_buf_wr, w_latch;
  logic                  w_dn_done, w_buf_hit;
  logic [31:0]           w_cw_req, w_load_addr, w_raw_addr, w_dict_word;
  logic [15:0]           w_half;
  logic                  w_unused;

  assign w_dn_done   = r_dn_valid & dn_ready;
  assign w_cw_req    = (CODE_BASE + (up_addr >> 1)) & ~32'h3;
  assign w_buf_hit   = r_buf_valid && (r_buf_tag == w_cw_req);
  assign w_load_addr = DICT_BASE + 32'({r_load_idx, 2'b00});
  assign w_raw_addr  = RAW_BASE + {r_addr, 2'b00};
  assign w_half      = r_addr[2] ? r_buf_data[31:16] : r_buf_data[15:0];
  assign w_dict_word = r_dict[w_half[DICT_BITS-1:0]];
  // code bits between the escape flag and the dictionary index are don't-care
  assign w_unused    = ^w_half;

  always_comb begin
    w_state_d     = r_state;
    w_load_idx_d  = r_load_idx;
    w_abort_d     = r_abort;
    w_up_ready_d  = 1'b0;
    w_up_rdata_d  = r_up_rdata;
    w_dn_valid_d  = r_dn_valid;
    w_dn_addr_d   = r_dn_addr;
    w_load_done_d = r_load_done;
    w_hit_inc     = 1'b0;
    w_raw_inc     = 1'b0;
    w_dict_wr     = 1'b0;
    w_buf_wr      = 1'b0;
    w_latch       = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (w_dn_done) begin
          w_dn_valid_d = 1'b0;
          w_dict_wr    = 1'b1;
          w_load_idx_d = r_load_idx + DICT_BITS'(1);
          if (r_load_idx == c_LAST_IDX) begin
            w_load_done_d = 1'b1;
            w_state_d     = S_IDLE;
          end
        end else if (!r_dn_valid) begin
          w_dn_valid_d = 1'b1;
          w_dn_addr_d  = w_load_addr;
        end
      end
      S_IDLE: begin
        w_abort_d = 1'b0;
        if (up_valid) begin
          w_latch = 1'b1;
          if (w_buf_hit) begin
            w_state_d = S_DECODE;
          end else begin
            w_state_d    = S_CODE;
            w_dn_valid_d = 1'b1;
            w_dn_addr_d  = w_cw_req;
          end
        end
      end
      S_CODE: begin
        // an abandoned request still lets its code fetch land in the buffer
        if (!up_valid) w_abort_d = 1'b1;
        if (w_dn_done) begin
          w_dn_valid_d = 1'b0;
          w_buf_wr     = 1'b1;
          w_state_d    = (r_abort || !up_valid) ? S_IDLE : S_DECODE;
        end
      end
      S_DECODE: begin
        if (!up_valid) begin
          w_state_d = S_IDLE;
        end else if (w_half[15]) begin
          w_up_ready_d = 1'b1;
          w_up_rdata_d = w_dict_word;
          w_hit_inc    = 1'b1;
          w_state_d    = S_RESP;
        end else begin
          w_state_d    = S_RAW;
          w_dn_valid_d = 1'b1;
          w_dn_addr_d  = w_raw_addr;
        end
      end
      S_RAW: begin
        if (!up_valid) w_abort_d = 1'b1;
        if (w_dn_done) begin
          w_dn_valid_d = 1'b0;
          if (r_abort || !up_valid) begin
            w_state_d = S_IDLE;
          end else begin
            w_up_ready_d = 1'b1;
            w_up_rdata_d = dn_rdata;
            w_raw_inc    = 1'b1;
            w_state_d    = S_RESP;
          end
        end
      end
      S_RESP: w_state_d = S_DROP;
      S_DROP: if (!up_valid) w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= S_LOAD;
      r_load_idx    <= '0;
      r_addr        <= '0;
      r_buf_data    <= '0;
      r_buf_tag     <= '0;
      r_buf_valid   <= 1'b0;
      r_abort       <= 1'b0;
      r_up_ready    <= 1'b0;
      r_up_rdata    <= '0;
      r_dn_valid    <= 1'b0;
      r_dn_addr     <= '0;
      r_load_done   <= 1'b0;
      r_dict_hits   <= '0;
      r_raw_fetches <= '0;
    end else begin
      r_state     <= w_state_d;
      r_load_idx  <= w_load_idx_d;
      r_abort     <= w_abort_d;
      r_up_ready  <= w_up_ready_d;
      r_up_rdata  <= w_up_rdata_d;
      r_dn_valid  <= w_dn_valid_d;
      r_dn_addr   <= w_dn_addr_d;
      r_load_done <= w_load_done_d;
      if (w_latch) r_addr <= up_addr[31:2];
      if (w_buf_wr) begin
        r_buf_data  <= dn_rdata;
        r_buf_tag   <= r_dn_addr;
        r_buf_valid <= 1'b1;
      end
      if (w_hit_inc) r_dict_hits   <= r_dict_hits + 32'd1;
      if (w_raw_inc) r_raw_fetches <= r_raw_fetches + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_dict_wr) r_dict[r_load_idx] <= dn_rdata;
  end

  assign up_ready    = r_up_ready;
  assign up_rdata    = r_up_rdata;
  assign dn_valid    = r_dn_valid;
  assign dn_addr     = r_dn_addr;
  assign load_done   = r_load_done;
  assign dict_hits   = r_dict_hits;
  assign raw_fetches = r_raw_fetches;

endmodule
`default_nettype wire

// File: tb/tb_icache_fill_decomp.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_fill_decomp
// Purpose  : Scoreboard bench for icache_fill_decomp with a small memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_fill_decomp;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        up_valid = 1'b0;
  logic        up_ready;
  logic [31:0] up_addr = '0;
  logic [31:0] up_rdata;
  logic        dn_valid;
  logic        dn_ready = 1'b0;
  logic [31:0] dn_addr;
  logic [31:0] dn_rdata = '0;
  logic        load_done;
  logic [31:0] dict_hits;
  logic [31:0] raw_fetches;

  icache_fill_decomp #(
    .DICT_ENTRIES(4),
    .DICT_BASE   (32'h0002_0000),
    .CODE_BASE   (32'h0001_0000),
    .RAW_BASE    (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_addr    (up_addr),
    .up_rdata   (up_rdata),
    .dn_valid   (dn_valid),
    .dn_ready   (dn_ready),
    .dn_addr    (dn_addr),
    .dn_rdata   (dn_rdata),
    .load_done  (load_done),
    .dict_hits  (dict_hits),
    .raw_fetches(raw_fetches)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_up [$];
  logic [31:0] exp_dn [$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_dn_cyc = -10;
  int dn_count = 0;
  int up_count = 0;
  int lat_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // memory: one-cycle wait after dn_valid is seen, single-cycle dn_ready pulse
  initial forever begin
    @(posedge clk);
    #2;
    if (dn_ready) begin
      dn_ready = 1'b0;
      lat_cnt  = 0;
    end else if (dn_valid === 1'b1) begin
      if (lat_cnt >= 1) begin
        dn_ready = 1'b1;
        dn_rdata = mem.exists(dn_addr) ? mem[dn_addr] : 32'h0;
        lat_cnt  = 0;
      end else begin
        lat_cnt++;
      end
    end else begin
      lat_cnt = 0;
    end
  end

  // monitor: compares every response and every memory access against the queues
  initial forever begin
    @(negedge clk);
    if (up_ready === 1'b1) begin
      up_count++;
      if (exp_up.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL up_ready unexpected: got data %h expected no response", up_rdata);
      end else begin
        check("up_rdata", up_rdata, exp_up.pop_front());
      end
    end
    if (dn_valid === 1'b1 && dn_ready === 1'b1) begin
      dn_count++;
      last_dn_cyc = cyc;
      if (exp_dn.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL dn access unexpected: got addr %h expected none", dn_addr);
      end else begin
        check("dn_addr", dn_addr, exp_dn.pop_front());
      end
    end
  end

  task automatic wait_up(input int hold, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (up_ready !== 1'b1 && lat < 100);
    if (up_ready !== 1'b1) timeout("up_ready");
    repeat (hold) @(negedge clk);
    up_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic req(input logic [31:0] a, input int hold, output int lat);
    up_addr  = a;
    up_valid = 1'b1;
    wait_up(hold, lat);
  endtask

  task automatic wait_load();
    for (int i = 0; i < 200 && load_done !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic wait_dn(input logic [31:0] a, input string name);
    int i;
    for (i = 0; i < 100; i++) begin
      if (dn_valid === 1'b1 && dn_addr === a) break;
      @(negedge clk);
    end
    if (i >= 100) timeout(name);
  endtask

  int lat;
  int dn0, up0;

  initial begin
    mem[32'h0002_0000] = 32'h1111_1111;
    mem[32'h0002_0004] = 32'h2222_2222;
    mem[32'h0002_0008] = 32'h3333_3333;
    mem[32'h0002_000C] = 32'h4444_4444;
    mem[32'h0001_0000] = 32'h8002_8001;
    mem[32'h0001_0004] = 32'h0000_0000;
    mem[32'h0000_0008] = 32'hDEAD_BEEF;
    mem[32'h0001_0020] = 32'h8003_8000;
    mem[32'h0001_0024] = 32'h8001_FFFE;
    mem[32'h0001_0028] = 32'h0000_0000;
    mem[32'h0000_0050] = 32'h1234_5678;
    mem[32'h0000_0054] = 32'hCAFE_F00D;
    mem[32'h0001_0030] = 32'h8000_8000;

    repeat (3) @(negedge clk);
    check("reset up_ready", {31'b0, up_ready}, 32'd0);
    check("reset dn_valid", {31'b0, dn_valid}, 32'd0);
    check("reset load_done", {31'b0, load_done}, 32'd0);
    check("reset dict_hits", dict_hits, 32'd0);
    check("reset raw_fetches", raw_fetches, 32'd0);
    check("reset up_rdata", up_rdata, 32'd0);
    check("reset dn_addr", dn_addr, 32'd0);

    // dictionary load with a fill request already pending
    exp_dn.push_back(32'h0002_0000);
    exp_dn.push_back(32'h0002_0004);
    exp_dn.push_back(32'h0002_0008);
    exp_dn.push_back(32'h0002_000C);
    exp_dn.push_back(32'h0001_0000);
    up_addr  = 32'h0;
    up_valid = 1'b1;
    resetn   = 1'b1;
    wait_load();
    check("load_done", {31'b0, load_done}, 32'd1);
    check("load_done timing", cyc - last_dn_cyc, 32'd1);
    check("dict reads", dn_count, 32'd4);
    check("no up_ready during load", up_count, 32'd0);
    exp_up.push_back(32'h2222_2222);
    wait_up(0, lat);

    // buffer hit: no memory access, two-cycle latency
    dn0 = dn_count;
    exp_up.push_back(32'h3333_3333);
    req(32'h4, 0, lat);
    check("buffer hit latency", lat, 32'd2);
    check("buffer hit dn count", dn_count - dn0, 32'd0);
    check("dict_hits after two", dict_hits, 32'd2);

    // escape
    exp_dn.push_back(32'h0001_0004);
    exp_dn.push_back(32'h0000_0008);
    exp_up.push_back(32'hDEAD_BEEF);
    req(32'h8, 0, lat);
    check("raw_fetches escape", raw_fetches, 32'd1);
    check("dict_hits escape", dict_hits, 32'd2);

    // sequential fill, up_valid held after each pulse
    dn0 = dn_count;
    up0 = up_count;
    exp_dn.push_back(32'h0001_0020);
    exp_dn.push_back(32'h0001_0024);
    exp_up.push_back(32'h1111_1111);
    exp_up.push_back(32'h4444_4444);
    exp_up.push_back(32'h3333_3333);
    exp_up.push_back(32'h2222_2222);
    req(32'h40, 3, lat);
    req(32'h44, 3, lat);
    check("seq hit latency 0x44", lat, 32'd2);
    req(32'h48, 3, lat);
    req(32'h4C, 3, lat);
    check("seq hit latency 0x4C", lat, 32'd2);
    check("seq code reads", dn_count - dn0, 32'd2);
    check("seq responses", up_count - up0, 32'd4);
    check("dict_hits seq", dict_hits, 32'd6);

    // abort while the raw fetch is outstanding
    up0 = up_count;
    exp_dn.push_back(32'h0001_0028);
    exp_dn.push_back(32'h0000_0050);
    up_addr  = 32'h50;
    up_valid = 1'b1;
    wait_dn(32'h0000_0050, "abort raw fetch");
    up_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("abort no response", up_count - up0, 32'd0);
    check("abort raw_fetches", raw_fetches, 32'd1);
    check("abort dn_valid idle", {31'b0, dn_valid}, 32'd0);
    check("abort dn drained", exp_dn.size(), 32'd0);

    // buffer kept from the aborted request: only the raw fetch happens
    exp_dn.push_back(32'h0000_0054);
    exp_up.push_back(32'hCAFE_F00D);
    req(32'h54, 0, lat);
    check("raw_fetches after abort", raw_fetches, 32'd2);

    // reset while a code fetch is outstanding
    up_addr  = 32'h60;
    up_valid = 1'b1;
    wait_dn(32'h0001_0030, "code fetch before reset");
    resetn   = 1'b0;
    up_valid = 1'b0;
    @(negedge clk);
    check("mid reset dn_valid", {31'b0, dn_valid}, 32'd0);
    check("mid reset load_done", {31'b0, load_done}, 32'd0);
    check("mid reset dict_hits", dict_hits, 32'd0);
    check("mid reset raw_fetches", raw_fetches, 32'd0);
    exp_dn.push_back(32'h0002_0000);
    exp_dn.push_back(32'h0002_0004);
    exp_dn.push_back(32'h0002_0008);
    exp_dn.push_back(32'h0002_000C);
    exp_dn.push_back(32'h0001_0028);
    exp_dn.push_back(32'h0000_0050);
    exp_up.push_back(32'h1234_5678);
    resetn = 1'b1;
    wait_load();
    check("reload load_done", {31'b0, load_done}, 32'd1);
    req(32'h50, 0, lat);
    check("post reset raw_fetches", raw_fetches, 32'd1);
    repeat (3) @(negedge clk);
    check("dn queue empty", exp_dn.size(), 32'd0);
    check("up queue empty", exp_up.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
